instr_cache_assoc: RTL and testbench

Set-associative, multi-port instruction cache that succeeds the direct-mapped two-port instruction cache between the fetch stage and the memory bus. It is parametrised in sets, ways, line words and fetch ports. It adds pseudo-LRU replacement, a single arbitrated refill engine with explicit states, merging of concurrent misses to the same line, and a one-cycle flush. Lookups stay registered with a one-cycle hit latency; misses are refilled a full line at a time from the memory bus.

---
 rtl/instr_cache_assoc_pkg.sv | 21 ++
 rtl/instr_cache_assoc_plru.sv | 71 +++++++
 rtl/instr_cache_assoc.sv | 271 +++++++++++++++++++++++++++
 tb/tb_instr_cache_assoc.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_cache_assoc_pkg.sv
// Shared types for the set-associative instruction cache: line state,
// refill FSM encoding and a saturating adder for the optional counters.
package instr_cache_assoc_pkg;

    typedef enum logic {
        INVALID = 1'b0,
        VALID   = 1'b1
    } cache_state_e;

    typedef enum logic {
        IDLE    = 1'b0,
        REQUEST = 1'b1
    } icache_fsm_e;

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/instr_cache_assoc_plru.sv
// Tree pseudo-LRU, one WAYS-1 bit tree per set. Each tree node points at the
// half that was NOT most recently touched; touches are applied in port order.
module icache_plru #(
    parameter int SETS    = 8,
    parameter int WAYS    = 2,
    parameter int TOUCHES = 3,
    parameter int IDX_W   = $clog2(SETS),
    parameter int WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic                           clock,
    input  logic                           clear,
    input  logic [TOUCHES-1:0]             touch_en,
    input  logic [TOUCHES-1:0][IDX_W-1:0]  touch_set,
    input  logic [TOUCHES-1:0][WAY_W-1:0]  touch_way,
    input  logic [IDX_W-1:0]               query_set,
    output logic [WAY_W-1:0]               victim
);

    generate
        if (WAYS == 1) begin : g_direct
            assign victim = '0;
        end else begin : g_tree
            localparam int LVL = $clog2(WAYS);

            logic [WAYS-2:0] tree_q [SETS];
            logic [WAYS-2:0] tree_d [SETS];
            int              node;
            logic            dir;

            always_comb begin
                tree_d = tree_q;
                for (int t = 0; t < TOUCHES; t++) begin
                    if (touch_en[t]) begin
                        for (int l = 0; l < LVL; l++) begin
                            for (int k = 0; k < (1 << l); k++) begin
                                if (k == (int'(touch_way[t]) >> (LVL - l)))
                                    tree_d[touch_set[t]][(1 << l) + k - 1] = ~touch_way[t][LVL - 1 - l];
                            end
                        end
                    end
                end
            end

            // Follow the node pointers from the root down to a leaf.
            always_comb begin
                victim = '0;
                node   = 0;
                dir    = 1'b0;
                for (int l = 0; l < LVL; l++) begin
                    dir = 1'b0;
                    for (int k = 0; k < (1 << l); k++) begin
                        if (k == node)
                            dir = tree_q[query_set][(1 << l) + k - 1];
                    end
                    victim[LVL - 1 - l] = dir;
                    node = 2 * node + (dir ? 1 : 0);
                end
            end

            always_ff @(posedge clock) begin
                for (int s = 0; s < SETS; s++) begin
                    if (clear)
                        tree_q[s] <= '0;
                    else
                        tree_q[s] <= tree_d[s];
                end
            end
        end
    endgenerate

endmodule

// File: rtl/instr_cache_assoc.sv
// Set-associative multi-port instruction cache with one shared line refill engine.
// Optional hit/miss counters are enabled by defining INSTR_CACHE_PERF_EN.
module instr_cache_assoc
    import instr_cache_assoc_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int SETS  = 8,
    parameter int WAYS  = 2,
    parameter int WORDS = 4,
    parameter int PORTS = 2
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        flush,
    input  logic [PORTS-1:0]            read,
    input  logic [PORTS-1:0][XLEN-1:0]  address_in,
    output logic [PORTS-1:0][XLEN-1:0]  instr,
    output logic [PORTS-1:0][XLEN-1:0]  address_out,
    output logic [PORTS-1:0]            hit,
    output logic                        mem_read,
    output logic [XLEN-1:0]             mem_address,
    input  logic [WORDS*XLEN-1:0]       mem_data,
    input  logic                        mem_ready
`ifdef INSTR_CACHE_PERF_EN
    ,
    output logic [31:0]                 hit_count,
    output logic [31:0]                 miss_count
`endif
);

    localparam int WSEL_W = $clog2(WORDS);
    localparam int OFF_W  = WSEL_W + 2;
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = XLEN - OFF_W - IDX_W;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef struct packed {
        logic [TAG_W-1:0]            tag;
        logic [WORDS-1:0][XLEN-1:0]  words;
        cache_state_e                state;
    } line_t;

    line_t lines_q [SETS][WAYS];

    logic [PORTS-1:0][IDX_W-1:0] look_idx;
    logic [PORTS-1:0]            look_hit;
    logic [PORTS-1:0][WAY_W-1:0] look_way;
    logic [PORTS-1:0][XLEN-1:0]  look_word;
    logic [PORTS-1:0][XLEN-1:0]  look_line;

    logic [PORTS-1:0]            hit_d, hit_q;
    logic [PORTS-1:0][XLEN-1:0]  instr_d, instr_q;
    logic [PORTS-1:0][XLEN-1:0]  address_out_d, address_out_q;

    logic [PORTS-1:0]            pend_valid_d, pend_valid_q;
    logic [PORTS-1:0][XLEN-1:0]  pend_addr_d, pend_addr_q;

    icache_fsm_e                 fsm_q;
    logic                        mem_read_q;
    logic [XLEN-1:0]             mem_address_q;
    logic                        pick_valid;
    logic [XLEN-1:0]             pick_addr;

    logic                        fill_we;
    logic [IDX_W-1:0]            fill_idx;
    logic [WAY_W-1:0]            fill_way;
    logic                        fill_found;
    line_t                       fill_line;
    logic [WAY_W-1:0]            plru_victim;

    logic [PORTS:0]              touch_en;
    logic [PORTS:0][IDX_W-1:0]   touch_set;
    logic [PORTS:0][WAY_W-1:0]   touch_way;

    always_comb begin
        for (int p = 0; p < PORTS; p++) begin
            look_idx[p]  = address_in[p][OFF_W +: IDX_W];
            look_line[p] = {address_in[p][XLEN-1:OFF_W], {OFF_W{1'b0}}};
            look_hit[p]  = 1'b0;
            look_way[p]  = '0;
            look_word[p] = '0;
            for (int w = 0; w < WAYS; w++) begin
                if (lines_q[look_idx[p]][w].state == VALID &&
                    lines_q[look_idx[p]][w].tag == address_in[p][XLEN-1 -: TAG_W]) begin
                    look_hit[p]  = 1'b1;
                    look_way[p]  = WAY_W'(w);
                    look_word[p] = lines_q[look_idx[p]][w].words[address_in[p][2 +: WSEL_W]];
                end
            end
        end
    end

    // A flush-cycle lookup reports a miss even if the line is still resident.
    always_comb begin
        for (int p = 0; p < PORTS; p++) begin
            hit_d[p]         = read[p] & look_hit[p] & ~flush;
            instr_d[p]       = hit_d[p] ? look_word[p] : '0;
            address_out_d[p] = hit_d[p] ? address_in[p] : '0;
        end
    end

    always_comb begin
        fill_we    = (fsm_q == REQUEST) & mem_ready & ~flush;
        fill_idx   = mem_address_q[OFF_W +: IDX_W];
        fill_way   = plru_victim;
        fill_found = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!fill_found && lines_q[fill_idx][w].state == INVALID) begin
                fill_way   = WAY_W'(w);
                fill_found = 1'b1;
            end
        end
        fill_line.tag   = mem_address_q[XLEN-1 -: TAG_W];
        fill_line.words = mem_data;
        fill_line.state = VALID;
    end

    // A miss to the line being written this cycle is already satisfied by that fill.
    always_comb begin
        for (int p = 0; p < PORTS; p++) begin
            pend_valid_d[p] = pend_valid_q[p];
            pend_addr_d[p]  = pend_addr_q[p];
            if (fill_we && pend_valid_q[p] && pend_addr_q[p] == mem_address_q)
                pend_valid_d[p] = 1'b0;
            if (read[p] && !look_hit[p] && !pend_valid_q[p] && !flush &&
                !(fill_we && look_line[p] == mem_address_q)) begin
                pend_valid_d[p] = 1'b1;
                pend_addr_d[p]  = look_line[p];
            end
        end
    end

    always_comb begin
        pick_valid = |pend_valid_q;
        pick_addr  = '0;
        for (int p = PORTS - 1; p >= 0; p--) begin
            if (pend_valid_q[p])
                pick_addr = pend_addr_q[p];
        end
    end

    always_comb begin
        for (int p = 0; p < PORTS; p++) begin
            touch_en[p]  = hit_d[p];
            touch_set[p] = look_idx[p];
            touch_way[p] = look_way[p];
        end
        touch_en[PORTS]  = fill_we;
        touch_set[PORTS] = fill_idx;
        touch_way[PORTS] = fill_way;
    end

    icache_plru #(
        .SETS    (SETS),
        .WAYS    (WAYS),
        .TOUCHES (PORTS + 1),
        .IDX_W   (IDX_W),
        .WAY_W   (WAY_W)
    ) u_plru (
        .clock     (clock),
        .clear     (reset | flush),
        .touch_en  (touch_en),
        .touch_set (touch_set),
        .touch_way (touch_way),
        .query_set (fill_idx),
        .victim    (plru_victim)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            hit_q         <= '0;
            instr_q       <= '0;
            address_out_q <= '0;
        end else begin
            hit_q         <= hit_d;
            instr_q       <= instr_d;
            address_out_q <= address_out_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || flush)
            pend_valid_q <= '0;
        else
            pend_valid_q <= pend_valid_d;
        pend_addr_q <= pend_addr_d;
    end

    // Line payloads are never reset; only the state field needs clearing.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++)
                    lines_q[s][w].state <= INVALID;
        end else if (fill_we) begin
            lines_q[fill_idx][fill_way] <= fill_line;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fsm_q         <= IDLE;
            mem_read_q    <= 1'b0;
            mem_address_q <= '0;
        end else if (flush) begin
            fsm_q      <= IDLE;
            mem_read_q <= 1'b0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (pick_valid) begin
                        fsm_q         <= REQUEST;
                        mem_read_q    <= 1'b1;
                        mem_address_q <= pick_addr;
                    end
                end
                REQUEST: begin
                    if (mem_ready) begin
                        fsm_q      <= IDLE;
                        mem_read_q <= 1'b0;
                    end
                end
                default: begin
                    fsm_q      <= IDLE;
                    mem_read_q <= 1'b0;
                end
            endcase
        end
    end

    assign hit         = hit_q;
    assign instr       = instr_q;
    assign address_out = address_out_q;
    assign mem_read    = mem_read_q;
    assign mem_address = mem_address_q;

`ifdef INSTR_CACHE_PERF_EN
    logic [31:0] hit_count_d, hit_count_q;
    logic [31:0] miss_count_d, miss_count_q;
    logic [31:0] n_hit, n_miss;

    always_comb begin
        n_hit  = '0;
        n_miss = '0;
        for (int p = 0; p < PORTS; p++) begin
            if (read[p]) begin
                if (hit_d[p])
                    n_hit = n_hit + 32'd1;
                else
                    n_miss = n_miss + 32'd1;
            end
        end
        hit_count_d  = sat_add32(hit_count_q, n_hit);
        miss_count_d = sat_add32(miss_count_q, n_miss);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_instr_cache_assoc.sv
// Directed bench for instr_cache_assoc (default parameters); the counter
// checks are compiled in only when INSTR_CACHE_PERF_EN is defined.
module tb_instr_cache_assoc;

    logic              clock = 1'b0;
    logic              reset;
    logic              flush;
    logic [1:0]        read;
    logic [1:0][31:0]  address_in;
    logic [1:0][31:0]  instr;
    logic [1:0][31:0]  address_out;
    logic [1:0]        hit;
    logic              mem_read;
    logic [31:0]       mem_address;
    logic [127:0]      mem_data;
    logic              mem_ready;
`ifdef INSTR_CACHE_PERF_EN
    logic [31:0]       hit_count;
    logic [31:0]       miss_count;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    instr_cache_assoc dut (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .read        (read),
        .address_in  (address_in),
        .instr       (instr),
        .address_out (address_out),
        .hit         (hit),
        .mem_read    (mem_read),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_ready   (mem_ready)
`ifdef INSTR_CACHE_PERF_EN
        ,
        .hit_count   (hit_count),
        .miss_count  (miss_count)
`endif
    );

    typedef struct {
        string       name;
        logic [1:0]  rd;
        logic [31:0] a0;
        logic [31:0] a1;
        logic        rdy;
        logic [31:0] base;
        logic [1:0]  e_hit;
        logic [31:0] e_i0;
        logic [31:0] e_ao0;
        logic [31:0] e_i1;
        logic [31:0] e_ao1;
        logic        e_mr;
        logic [31:0] e_ma;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [127:0] mk_line(input logic [31:0] base);
        logic [127:0] line;
        for (int w = 0; w < 4; w++)
            line[w*32 +: 32] = base + 32'h11 * 32'(w + 1);
        return line;
    endfunction

    task automatic lookup(input logic [1:0] r, input logic [31:0] a0, input logic [31:0] a1);
        read          = r;
        address_in[0] = a0;
        address_in[1] = a1;
        tick();
        read = 2'b00;
    endtask

    task automatic chk_port(input string name, input int p, input logic h,
                            input logic [31:0] i, input logic [31:0] ao);
        chk({name, "_hit"}, 32'(hit[p]), 32'(h));
        chk({name, "_instr"}, instr[p], i);
        chk({name, "_addr"}, address_out[p], ao);
    endtask

    task automatic wait_req(input string name, input logic [31:0] ea);
        int n = 0;
        while (!mem_read && n < 20) begin
            tick();
            n++;
        end
        chk({name, "_mem_read"}, 32'(mem_read), 32'd1);
        chk({name, "_mem_address"}, mem_address, ea);
    endtask

    task automatic serve(input string name, input logic [31:0] ea, input logic [31:0] base);
        wait_req(name, ea);
        mem_ready = 1'b1;
        mem_data  = mk_line(base);
        tick();
        mem_ready = 1'b0;
        chk({name, "_drop"}, 32'(mem_read), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //            name          rd     a0      a1      rdy base     e_hit e_i0    e_ao0   e_i1    e_ao1   mr ma
        vecs[0]  = '{"miss_100",    2'b01, 32'h100, 32'h0,   0, 32'h0,    2'b00, 32'h0,   32'h0,   32'h0,   32'h0,   0, 32'h0};
        vecs[1]  = '{"req_100",     2'b00, 32'h0,   32'h0,   0, 32'h0,    2'b00, 32'h0,   32'h0,   32'h0,   32'h0,   1, 32'h100};
        vecs[2]  = '{"hold_100",    2'b00, 32'h0,   32'h0,   0, 32'h0,    2'b00, 32'h0,   32'h0,   32'h0,   32'h0,   1, 32'h100};
        vecs[3]  = '{"fill_100",    2'b00, 32'h0,   32'h0,   1, 32'h0,    2'b00, 32'h0,   32'h0,   32'h0,   32'h0,   0, 32'h0};
        vecs[4]  = '{"hit_108",     2'b01, 32'h108, 32'h0,   0, 32'h0,    2'b01, 32'h33,  32'h108, 32'h0,   32'h0,   0, 32'h0};
        vecs[5]  = '{"hit_both",    2'b11, 32'h100, 32'h10C, 0, 32'h0,    2'b11, 32'h11,  32'h100, 32'h44,  32'h10C, 0, 32'h0};
        vecs[6]  = '{"miss_200_204",2'b11, 32'h200, 32'h204, 0, 32'h0,    2'b00, 32'h0,   32'h0,   32'h0,   32'h0,   0, 32'h0};
        vecs[7]  = '{"req_200",     2'b00, 32'h0,   32'h0,   0, 32'h0,    2'b00, 32'h0,   32'h0,   32'h0,   32'h0,   1, 32'h200};
        vecs[8]  = '{"fill_200",    2'b00, 32'h0,   32'h0,   1, 32'h1000, 2'b00, 32'h0,   32'h0,   32'h0,   32'h0,   0, 32'h0};
        vecs[9]  = '{"no_dup_200",  2'b00, 32'h0,   32'h0,   0, 32'h0,    2'b00, 32'h0,   32'h0,   32'h0,   32'h0,   0, 32'h0};
        vecs[10] = '{"hit_200_204", 2'b11, 32'h200, 32'h204, 0, 32'h0,    2'b11, 32'h1011,32'h200, 32'h1022,32'h204, 0, 32'h0};
        vecs[11] = '{"idle_zero",   2'b00, 32'h200, 32'h204, 0, 32'h0,    2'b00, 32'h0,   32'h0,   32'h0,   32'h0,   0, 32'h0};

        reset      = 1'b1;
        flush      = 1'b0;
        read       = 2'b00;
        address_in = '0;
        mem_data   = '0;
        mem_ready  = 1'b0;
        tick();
        tick();
        chk_port("reset_p0", 0, 1'b0, 32'h0, 32'h0);
        chk_port("reset_p1", 1, 1'b0, 32'h0, 32'h0);
        chk("reset_mem_read", 32'(mem_read), 32'd0);
        chk("reset_mem_address", mem_address, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            read          = vecs[i].rd;
            address_in[0] = vecs[i].a0;
            address_in[1] = vecs[i].a1;
            mem_ready     = vecs[i].rdy;
            mem_data      = mk_line(vecs[i].base);
            tick();
            mem_ready = 1'b0;
            chk({vecs[i].name, "_hit"}, 32'(hit), 32'(vecs[i].e_hit));
            chk({vecs[i].name, "_i0"}, instr[0], vecs[i].e_i0);
            chk({vecs[i].name, "_ao0"}, address_out[0], vecs[i].e_ao0);
            chk({vecs[i].name, "_i1"}, instr[1], vecs[i].e_i1);
            chk({vecs[i].name, "_ao1"}, address_out[1], vecs[i].e_ao1);
            chk({vecs[i].name, "_mr"}, 32'(mem_read), 32'(vecs[i].e_mr));
            if (vecs[i].e_mr)
                chk({vecs[i].name, "_ma"}, mem_address, vecs[i].e_ma);
        end
        read = 2'b00;

        // Flush with a resident line being looked up: miss, and nothing pends.
        flush = 1'b1;
        lookup(2'b01, 32'h100, 32'h0);
        flush = 1'b0;
        chk_port("flush_lookup", 0, 1'b0, 32'h0, 32'h0);
        tick();
        tick();
        chk("flush_no_pend", 32'(mem_read), 32'd0);

        // PLRU eviction within set 0.
        lookup(2'b01, 32'h000, 32'h0);
        chk_port("ev_miss_000", 0, 1'b0, 32'h0, 32'h0);
        serve("ev_fill_000", 32'h000, 32'h2000);
        lookup(2'b01, 32'h080, 32'h0);
        chk_port("ev_miss_080", 0, 1'b0, 32'h0, 32'h0);
        serve("ev_fill_080", 32'h080, 32'h3000);
        lookup(2'b01, 32'h000, 32'h0);
        chk_port("ev_hit_000", 0, 1'b1, 32'h2011, 32'h000);
        lookup(2'b01, 32'h100, 32'h0);
        serve("ev_fill_100", 32'h100, 32'h4000);
        lookup(2'b01, 32'h104, 32'h0);
        chk_port("ev_hit_104", 0, 1'b1, 32'h4022, 32'h104);
        lookup(2'b11, 32'h000, 32'h080);
        chk_port("ev_keep_000", 0, 1'b1, 32'h2011, 32'h000);
        chk_port("ev_gone_080", 1, 1'b0, 32'h0, 32'h0);
        serve("ev_refill_080", 32'h080, 32'h3000);

        // Two ports miss different lines: port 0 first, one idle cycle between.
        lookup(2'b11, 32'h300, 32'h400);
        chk_port("pri_miss_p0", 0, 1'b0, 32'h0, 32'h0);
        chk_port("pri_miss_p1", 1, 1'b0, 32'h0, 32'h0);
        serve("pri_first_300", 32'h300, 32'h5000);
        serve("pri_second_400", 32'h400, 32'h6000);
        lookup(2'b11, 32'h308, 32'h40C);
        chk_port("pri_hit_308", 0, 1'b1, 32'h5033, 32'h308);
        chk_port("pri_hit_40c", 1, 1'b1, 32'h6044, 32'h40C);

        // Flush during an outstanding refill; the late line must be dropped.
        lookup(2'b01, 32'h500, 32'h0);
        wait_req("fl_req_500", 32'h500);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_mem_read_drop", 32'(mem_read), 32'd0);
        mem_ready = 1'b1;
        mem_data  = mk_line(32'h7000);
        tick();
        mem_ready = 1'b0;
        chk("fl_late_ready", 32'(mem_read), 32'd0);
        tick();
        chk("fl_idle", 32'(mem_read), 32'd0);
        lookup(2'b11, 32'h308, 32'h500);
        chk_port("fl_miss_308", 0, 1'b0, 32'h0, 32'h0);
        chk_port("fl_miss_500", 1, 1'b0, 32'h0, 32'h0);

`ifdef INSTR_CACHE_PERF_EN
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("perf_reset_hits", hit_count, 32'd0);
        chk("perf_reset_misses", miss_count, 32'd0);
        lookup(2'b01, 32'h000, 32'h0);
        serve("perf_fill_000", 32'h000, 32'h0);
        lookup(2'b01, 32'h000, 32'h0);
        lookup(2'b01, 32'h004, 32'h0);
        lookup(2'b01, 32'h008, 32'h0);
        lookup(2'b01, 32'h700, 32'h0);
        chk("perf_hits", hit_count, 32'd3);
        chk("perf_misses", miss_count, 32'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("perf_clear_hits", hit_count, 32'd0);
        chk("perf_clear_misses", miss_count, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
